// File: rtl/uart_instr_loader_pkg.sv
// Shared definitions for the UART instruction loader: data width and the
// state encodings of the receiver and loader FSMs.
package uart_instr_loader_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_WAIT_HDR = 2'd0,
        LD_LOAD     = 2'd1,
        LD_DONE     = 2'd2
    } ld_state_t;

endpackage

// File: rtl/uart_instr_loader_if.sv
// Instruction-memory write port: the loader drives it, the memory samples it
// only while imem_we is high.
interface uart_instr_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    import uart_instr_loader_pkg::*;

    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [XLEN-1:0]       imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);

endinterface

// File: rtl/uart_instr_loader_rx_core.sv
// 8N1 UART receiver: input synchroniser, down-counting bit timer and RX FSM.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   RX_IDLE  | line idle, waiting for a synchronised 0
//   RX_START | half a bit into the start bit; re-check it is still 0
//   RX_DATA  | sampling 8 data bits LSB first, one per bit period
//   RX_STOP  | sampling the stop bit; on a low stop bit wait for line high
module uart_rx_core
    import uart_instr_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync;
    logic          rx_s;
    rx_state_t     state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          stop_bad;

    assign rx_s = sync[1];

    // Two-flop synchroniser, preset to the idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], uart_rx};
    end

    // Receiver FSM; timer terminal count (zero) marks each sample point.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            stop_bad   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state <= RX_START;
                        timer <= HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (!rx_s) begin
                        state   <= RX_DATA;
                        timer   <= FULL_LOAD;
                        bit_cnt <= '0;
                    end else begin
                        state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        shift <= {rx_s, shift[7:1]};
                        timer <= FULL_LOAD;
                        if (bit_cnt == 3'd7) state <= RX_STOP;
                        else                 bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (stop_bad) begin
                        if (rx_s) begin
                            stop_bad <= 1'b0;
                            state    <= RX_IDLE;
                        end
                    end else if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (rx_s) begin
                        rx_byte    <= shift;
                        byte_valid <= 1'b1;
                        state      <= RX_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        stop_bad  <= 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_instr_loader.sv
// UART boot loader: header byte gives the word count, following bytes are
// packed little-endian into 32-bit words and written to instruction memory.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   LD_WAIT_HDR | waiting for the header byte (word count N)
//   LD_LOAD     | packing bytes into words and strobing them into memory
//   LD_DONE     | load finished; all further bytes ignored until reset
module uart_instr_loader
    import uart_instr_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    uart_instr_loader_if.master  imem,
    output logic                 load_busy,
    output logic                 load_done,
    output logic                 frame_err
);

    logic [7:0]            rx_byte;
    logic                  byte_valid;
    ld_state_t             state;
    logic [7:0]            words_left;
    logic [1:0]            byte_idx;
    logic [23:0]           partial;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;

    // Loader FSM with word packer; partial word is kept apart from wdata so
    // the memory-facing data only changes on a strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= LD_WAIT_HDR;
            words_left <= '0;
            byte_idx   <= '0;
            partial    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                LD_WAIT_HDR: begin
                    if (byte_valid) begin
                        if (rx_byte == 8'd0) begin
                            load_done <= 1'b1;
                            state     <= LD_DONE;
                        end else begin
                            words_left <= rx_byte;
                            byte_idx   <= '0;
                            load_busy  <= 1'b1;
                            state      <= LD_LOAD;
                        end
                    end
                end
                LD_LOAD: begin
                    if (we_q) begin
                        addr_q     <= addr_q + 1'b1;
                        words_left <= words_left - 1'b1;
                        if (words_left == 8'd1) begin
                            load_busy <= 1'b0;
                            load_done <= 1'b1;
                            state     <= LD_DONE;
                        end
                    end
                    if (byte_valid) begin
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            wdata_q <= {rx_byte, partial};
                            we_q    <= 1'b1;
                        end else begin
                            partial <= {rx_byte, partial[23:8]};
                        end
                    end
                end
                LD_DONE: ;
                default: state <= LD_WAIT_HDR;
            endcase
        end
    end

endmodule
